// File: rtl/reg_file_mp_pkg.sv
// Shared CPU definitions for the multi-ported register file: default widths,
// the hard-wired zero register index and a writability helper.
package reg_file_mp_pkg;

  localparam int unsigned CPU_DATA_W   = 32;
  localparam int unsigned CPU_ADDR_W   = 5;
  localparam int unsigned ZERO_REG_IDX = 0;

  // An address is usable for write, issue or busy unless it is the hard-wired zero register
  function automatic bit addr_allowed(input bit zero_reg_en, input int unsigned addr);
    return !(zero_reg_en && (addr == ZERO_REG_IDX));
  endfunction

endpackage

// File: rtl/reg_file_mp_rf_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared by writes,
// wiped by flush, with a bypass-aware busy lookup per read port.
module rf_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic             w_iss_ok;

  assign w_iss_ok = iss_en && addr_allowed(ZR, 32'(iss_addr));

  // One-hot set/clear masks for this cycle's issue and effective writes
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_iss_ok) begin
      w_set = DEPTH'(1) << iss_addr;
    end else begin
      w_set = '0;
    end
    if (wr0_en) begin
      w_clr = w_clr | (DEPTH'(1) << wr0_addr);
    end else begin
      w_clr = w_clr;
    end
    if (wr1_en) begin
      w_clr = w_clr | (DEPTH'(1) << wr1_addr);
    end else begin
      w_clr = w_clr;
    end
  end

  // Busy vector: flush beats issue, issue beats a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit  = (wr0_en && (wr0_addr == w_addr)) || (wr1_en && (wr1_addr == w_addr));
    assign rd_busy[k] = rst_n && r_busy[w_addr] && !w_hit && addr_allowed(ZR, 32'(w_addr));
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with same-cycle write bypass and a
// busy scoreboard for outstanding producers.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_we0_eff;
  logic              w_we1_eff;

  // Nothing written while reset is held, and the zero register is read-only
  assign w_we0_eff = rst_n && we0 && addr_allowed(ZR, 32'(wa0));
  assign w_we1_eff = rst_n && we1 && addr_allowed(ZR, 32'(wa1));

  // Storage; port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_we0_eff) begin
        r_regs[wa0] <= wd0;
      end
      if (w_we1_eff) begin
        r_regs[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux: zero register, then younger write, then older write, then storage
    always_comb begin
      w_data = '0;
      if (!rst_n) begin
        w_data = '0;
      end else if (!addr_allowed(ZR, 32'(w_addr))) begin
        w_data = '0;
      end else if (we1 && (wa1 == w_addr)) begin
        w_data = wd1;
      end else if (we0 && (wa0 == w_addr)) begin
        w_data = wd0;
      end else begin
        w_data = r_regs[w_addr];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wr0_en   (w_we0_eff),
    .wr0_addr (wa0),
    .wr1_en   (w_we1_eff),
    .wr1_addr (wa1),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a default instance (ZERO_REG=1, 2 ports, 32 bits) and a
// swept instance (ZERO_REG=0, 3 ports, 16 bits) share stimulus against an array model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1, iss_en, flush;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [4:0]  ra [3];

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [14:0] b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;

  logic [31:0] m  [2][32];
  bit          bz [2][32];
  int          n_cmp = 0;
  int          n_err = 0;

  assign a_rd_addr = {ra[1], ra[0]};
  assign b_rd_addr = {ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  reg_file_mp u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0[15:0]), .we1(we1), .wa1(wa1), .wd1(wd1[15:0]),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit zr(input int d);
    return d == 0;
  endfunction

  function automatic logic [31:0] mask(input int d, input logic [31:0] v);
    return (d == 1) ? {16'h0000, v[15:0]} : v;
  endfunction

  function automatic logic [31:0] exp_data(input int d, input logic [4:0] a);
    if (!rst_n) return 32'h0;
    if (zr(d) && a == 5'd0) return 32'h0;
    if (we1 && wa1 == a) return mask(d, wd1);
    if (we0 && wa0 == a) return mask(d, wd0);
    return m[d][a];
  endfunction

  function automatic bit exp_busy(input int d, input logic [4:0] a);
    if (!rst_n) return 1'b0;
    if (zr(d) && a == 5'd0) return 1'b0;
    if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
    return bz[d][a];
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        m[d][i]  = 32'h0;
        bz[d][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      if (we0 && !(zr(d) && wa0 == 5'd0)) begin m[d][wa0] = mask(d, wd0); bz[d][wa0] = 1'b0; end
      if (we1 && !(zr(d) && wa1 == 5'd0)) begin m[d][wa1] = mask(d, wd1); bz[d][wa1] = 1'b0; end
      if (iss_en && !(zr(d) && iss_addr == 5'd0)) bz[d][iss_addr] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) bz[d][i] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s A.data%0d", tag, k), a_rd_data[k*32 +: 32], exp_data(0, ra[k]));
      check_eq($sformatf("%s A.busy%0d", tag, k), {31'b0, a_rd_busy[k]}, {31'b0, exp_busy(0, ra[k])});
    end
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s B.data%0d", tag, k), {16'h0000, b_rd_data[k*16 +: 16]}, exp_data(1, ra[k]));
      check_eq($sformatf("%s B.busy%0d", tag, k), {31'b0, b_rd_busy[k]}, {31'b0, exp_busy(1, ra[k])});
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; flush = 1'b0;
    wa0 = 5'd0; wa1 = 5'd0; iss_addr = 5'd0; wd0 = 32'h0; wd1 = 32'h0;
  endtask

  task automatic mid(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) ra[k] = 5'd0;
    clear_model();

    // Activity while held in reset must be invisible and have no effect
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hCAFE_F00D; iss_en = 1'b1; iss_addr = 5'd9;
    ra[0] = 5'd9; ra[1] = 5'd9; ra[2] = 5'd1;
    mid("in_reset");
    check_eq("reset_data", a_rd_data[31:0], 32'h0);
    edge_step();
    idle();
    mid("reset_after");
    rst_n = 1'b1;
    edge_step();

    // Write then read
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    mid("wtr_w");
    edge_step();
    idle(); ra[0] = 5'd5;
    mid("wtr_r");
    check_eq("wtr", a_rd_data[31:0], 32'hDEAD_BEEF);
    edge_step();

    // Dual write to one address with same-cycle bypass
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra[1] = 5'd7;
    mid("dual");
    check_eq("bypass", a_rd_data[63:32], 32'h22);
    edge_step();
    idle();
    mid("dual_after");
    check_eq("dual_store", a_rd_data[63:32], 32'h22);
    edge_step();

    // Zero register on A; ordinary register 0 on B
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 5'd0; ra[0] = 5'd0;
    mid("zero");
    check_eq("zero_data", a_rd_data[31:0], 32'h0);
    check_eq("zero_busy", {31'b0, a_rd_busy[0]}, 32'h0);
    edge_step();
    idle();
    mid("zero_after");
    check_eq("zero_data_after", a_rd_data[31:0], 32'h0);
    check_eq("zero_busy_after", {31'b0, a_rd_busy[0]}, 32'h0);
    check_eq("b_reg0_busy", {31'b0, b_rd_busy[0]}, 32'h1);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h0000_ABCD;
    edge_step();
    idle();
    mid("b_reg0");
    check_eq("b_reg0_data", {16'h0, b_rd_data[15:0]}, 32'hABCD);
    edge_step();

    // Scoreboard set / clear / set-wins
    iss_en = 1'b1; iss_addr = 5'd3; ra[0] = 5'd3;
    mid("sb_iss");
    edge_step();
    idle();
    mid("sb_busy");
    check_eq("sb_busy", {31'b0, a_rd_busy[0]}, 32'h1);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5A;
    mid("sb_wr");
    check_eq("sb_wr_bypass", {31'b0, a_rd_busy[0]}, 32'h0);
    edge_step();
    idle();
    mid("sb_clr");
    check_eq("sb_cleared", {31'b0, a_rd_busy[0]}, 32'h0);
    iss_en = 1'b1; iss_addr = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h6B;
    mid("sb_both");
    edge_step();
    idle();
    mid("sb_set_wins");
    check_eq("sb_set_wins", {31'b0, a_rd_busy[0]}, 32'h1);
    edge_step();

    // Flush overrides issue
    foreach (ra[k]) ra[k] = 5'd0;
    iss_en = 1'b1; iss_addr = 5'd1; edge_step();
    iss_addr = 5'd2; edge_step();
    iss_addr = 5'd9; edge_step();
    ra[0] = 5'd1; ra[1] = 5'd9; ra[2] = 5'd4;
    idle();
    mid("pre_flush");
    check_eq("pre_flush_busy", {31'b0, a_rd_busy[1]}, 32'h1);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
    edge_step();
    idle();
    mid("post_flush");
    check_eq("flush_b4", {31'b0, b_rd_busy[2]}, 32'h0);
    check_eq("flush_a1", {31'b0, a_rd_busy[0]}, 32'h0);
    edge_step();

    // Asynchronous reset mid-cycle
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77; ra[0] = 5'd9;
    edge_step();
    idle();
    mid("pre_rst");
    check_eq("reg9", a_rd_data[31:0], 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst", a_rd_data[31:0], 32'h0);
    clear_model();
    check_all("async_rst");
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234; iss_en = 1'b1; iss_addr = 5'd9;
    edge_step();
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55; iss_en = 1'b0;
    mid("first_edge");
    edge_step();
    idle();
    mid("first_edge_after");
    check_eq("first_edge", a_rd_data[31:0], 32'h55);
    edge_step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = $urandom();
      we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = $urandom();
      iss_en = 1'($urandom_range(0, 1)); iss_addr = rnd_addr();
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 3; k++) ra[k] = rnd_addr();
      mid("rnd");
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
